// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for a 6-entry code table (HC/M).
// It latches the table, shifts in stream bits under a valid/ready handshake
// and emits one gray level for each matched codeword until NUM_PIX symbols are decoded.
module huffman_decoder #(
    parameter int unsigned NUM_SYM = 6,
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned NUM_PIX = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     code_valid,
    input  logic [NUM_SYM*SYM_W-1:0] HC,
    input  logic [NUM_SYM*SYM_W-1:0] M,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    output logic                     bit_ready,
    output logic                     gray_valid,
    output logic [SYM_W-1:0]         gray_data,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned TAB_W = NUM_SYM * SYM_W;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned IDX_W = $clog2(NUM_SYM);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    logic [1:0]         state, state_n;
    // The accumulator never holds a complete MAX_LEN-bit word: the last bit either matches or errors.
    logic [MAX_LEN-2:0] acc, acc_n;
    logic [LEN_W-1:0]   blen, blen_n;
    logic [CNT_W-1:0]   sym_cnt, cnt_n;
    logic               load_tab;

    logic [SYM_W-1:0]   hc_tab  [NUM_SYM];
    logic [SYM_W-1:0]   m_tab   [NUM_SYM];
    logic [LEN_W-1:0]   len_tab [NUM_SYM];

    logic [MAX_LEN-1:0] acc_shift;
    logic [LEN_W-1:0]   blen_inc;
    logic               accept;
    logic               match;
    logic [IDX_W-1:0]   match_idx;

    logic               bit_ready_n;
    logic               gray_valid_n;
    logic [SYM_W-1:0]   gray_data_n;
    logic               done_n;
    logic               err_n;

    function automatic logic [LEN_W-1:0] popcnt(input logic [SYM_W-1:0] v);
        logic [LEN_W-1:0] c;
        c = '0;
        for (int k = 0; k < SYM_W; k++) begin
            c = c + LEN_W'(v[k]);
        end
        return c;
    endfunction

    assign acc_shift = {acc, bit_in};
    assign blen_inc  = blen + LEN_W'(1);
    assign accept    = bit_valid && bit_ready;

    // Compare the would-be accumulator against every table entry; lowest index wins.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (!match && (len_tab[i] != '0) && (len_tab[i] == blen_inc) &&
                ((SYM_W'(acc_shift) & m_tab[i]) == (hc_tab[i] & m_tab[i]))) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        acc_n        = acc;
        blen_n       = blen;
        cnt_n        = sym_cnt;
        load_tab     = 1'b0;
        gray_valid_n = 1'b0;
        gray_data_n  = '0;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                if (code_valid) begin
                    load_tab = 1'b1;
                    acc_n    = '0;
                    blen_n   = '0;
                    cnt_n    = '0;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                if (accept) begin
                    if (match) begin
                        gray_valid_n = 1'b1;
                        gray_data_n  = SYM_W'(match_idx) + SYM_W'(1);
                        acc_n        = '0;
                        blen_n       = '0;
                        cnt_n        = sym_cnt + CNT_W'(1);
                        if (sym_cnt == CNT_W'(NUM_PIX - 1)) begin
                            state_n = DONE;
                        end
                    end else if (blen_inc == LEN_W'(MAX_LEN)) begin
                        acc_n   = '0;
                        blen_n  = '0;
                        state_n = ERR;
                    end else begin
                        acc_n  = acc_shift[MAX_LEN-2:0];
                        blen_n = blen_inc;
                    end
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            ERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        bit_ready_n = (state_n == DECODE);
        err_n       = (state_n == ERR);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            blen       <= '0;
            sym_cnt    <= '0;
            bit_ready  <= 1'b0;
            gray_valid <= 1'b0;
            gray_data  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            blen       <= blen_n;
            sym_cnt    <= cnt_n;
            bit_ready  <= bit_ready_n;
            gray_valid <= gray_valid_n;
            gray_data  <= gray_data_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

    // Code table: captured only when leaving IDLE, so it is stable for a whole image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                hc_tab[i]  <= '0;
                m_tab[i]   <= '0;
                len_tab[i] <= '0;
            end
        end else if (load_tab) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                hc_tab[i]  <= HC[TAB_W-1-SYM_W*i -: SYM_W];
                m_tab[i]   <= M[TAB_W-1-SYM_W*i -: SYM_W];
                len_tab[i] <= popcnt(M[TAB_W-1-SYM_W*i -: SYM_W]);
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed testbench for huffman_decoder using the 6-symbol table T.
module tb_huffman_decoder;

    localparam logic [47:0] T_HC = 48'h01_01_00_03_05_04;
    localparam logic [47:0] T_M  = 48'h01_03_07_0F_1F_1F;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [47:0] HC;
    logic [47:0] M;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_ready;
    logic        gray_valid;
    logic [7:0]  gray_data;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    int cyc = 0, gv_cnt = 0, done_cnt = 0, err_cnt = 0, multi_cnt = 0;
    int last_gv_cyc = 0, done_cyc = 0;
    logic [7:0] gq[$];

    huffman_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC         (HC),
        .M          (M),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc++;
        if (gray_valid) begin
            gq.push_back(gray_data);
            gv_cnt++;
            last_gv_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
        if ((int'(gray_valid) + int'(done) + int'(err)) > 1) multi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cw(input int s);
        case (s)
            1: return 8'b1;
            2: return 8'b01;
            3: return 8'b000;
            4: return 8'b0011;
            5: return 8'b00101;
            default: return 8'b00100;
        endcase
    endfunction

    function automatic int cl(input int s);
        case (s)
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 4;
            default: return 5;
        endcase
    endfunction

    // All tasks start and end on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [47:0] h, input logic [47:0] m);
        HC = h;
        M = m;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int t;
        t = 0;
        while (!bit_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bit_ready) check("rdy_timeout", bit_ready, 1);
        bit_valid = 1'b1;
        bit_in = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic send_code(input int s);
        logic [7:0] c;
        c = cw(s);
        for (int k = cl(s) - 1; k >= 0; k--) send_bit(c[k]);
    endtask

    initial begin
        int base, qb, bad, ebase;
        reset = 1'b1;
        code_valid = 1'b0;
        HC = '0;
        M = '0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bit_ready, 0);
        check("rst_gv", gray_valid, 0);
        check("rst_gd", gray_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic decode and latency
        load(T_HC, T_M);
        check("t1_ready", bit_ready, 1);
        send_bit(1'b1);
        check("t1_gv1", gray_valid, 1);
        check("t1_gd1", gray_data, 1);
        send_bit(1'b0);
        check("t1_nogv", gray_valid, 0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t1_gv5", gray_valid, 1);
        check("t1_gd5", gray_data, 5);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        check("t1_gv3", gray_valid, 1);
        check("t1_gd3", gray_data, 3);

        // 6: code_valid during DECODE is ignored
        HC = 48'h00_00_00_00_00_00;
        M = 48'h01_01_01_01_01_01;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        check("t6_ready", bit_ready, 1);
        send_bit(1'b0);
        check("t6_ignored", gray_valid, 0);
        send_bit(1'b1);
        check("t6_gv2", gray_valid, 1);
        check("t6_gd2", gray_data, 2);

        // 2: full image of 100 symbols
        do_reset();
        load(T_HC, T_M);
        #1;
        base = gv_cnt;
        qb = gq.size();
        for (int n = 0; n < 100; n++) send_code(n % 6 + 1);
        check("t2_last_gv", gray_valid, 1);
        check("t2_last_gd", gray_data, 4);
        check("t2_no_early_done", done, 0);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_ready_off", bit_ready, 0);
        check("t2_gv_off", gray_valid, 0);
        #1;
        check("t2_count", gv_cnt - base, 100);
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            if (gq.size() <= qb + n) bad++;
            else if (gq[qb + n] != 8'(n % 6 + 1)) bad++;
        end
        check("t2_order", bad, 0);
        check("t2_done_lat", done_cyc, last_gv_cyc + 1);
        @(negedge clk);
        check("t2_done_once", done, 0);
        check("t2_idle_ready", bit_ready, 0);

        // 3: gaps in bit_valid
        do_reset();
        load(T_HC, T_M);
        #1;
        base = gv_cnt;
        send_bit(1'b0); repeat (3) @(negedge clk);
        send_bit(1'b0); repeat (3) @(negedge clk);
        send_bit(1'b1); repeat (3) @(negedge clk);
        send_bit(1'b1);
        check("t3_gv4", gray_valid, 1);
        check("t3_gd4", gray_data, 4);
        repeat (3) @(negedge clk);
        #1;
        check("t3_count", gv_cnt - base, 1);

        // 4: no match within MAX_LEN bits
        do_reset();
        load(48'h01_00_00_00_00_00, 48'h01_00_00_00_00_00);
        #1;
        base = gv_cnt;
        ebase = err_cnt;
        for (int k = 0; k < 8; k++) send_bit(1'b0);
        check("t4_err", err, 1);
        check("t4_gv", gray_valid, 0);
        check("t4_ready", bit_ready, 0);
        @(negedge clk);
        check("t4_err_once", err, 0);
        #1;
        check("t4_no_gv", gv_cnt - base, 0);
        check("t4_err_cnt", err_cnt - ebase, 1);
        load(T_HC, T_M);
        send_bit(1'b1);
        check("t4_reload_gd", gray_data, 1);

        // 5: reset mid-codeword
        do_reset();
        load(T_HC, T_M);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        #1;
        base = gv_cnt;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_ready", bit_ready, 0);
        check("t5_rst_gv", gray_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        load(T_HC, T_M);
        send_bit(1'b1);
        check("t5_gv1", gray_valid, 1);
        check("t5_gd1", gray_data, 1);
        #1;
        check("t5_count", gv_cnt - base, 1);

        check("no_overlap", multi_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
